seven_seg_scan_ctrl: RTL and testbench

- Time-multiplexes a 4-digit common-anode seven-segment display from one 16-bit hex value.
- Scan rate comes from the 250 Hz square wave produced by the board clock divider.
- Sits between the divider and the display pins.
- New display data is double-buffered and committed only at frame boundaries, so a frame never mixes old and new data.

---
 rtl/seven_seg_scan_ctrl.sv | 177 +++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit common-anode seven-segment scanner driven by an external 250 Hz scan clock.
// Display data is double-buffered and only committed on the 3->0 digit wrap.
module seven_seg_scan_ctrl #(
  parameter int DEAD_CYCLES   = 4,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_clk,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  digit_idx,
  output logic        frame_done,
  output logic        loaded
);

  typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  idx_d;
  logic        sync_p0, sync_p1, hist_p2;
  logic        step, wrap;
  logic [15:0] act_val, pend_val;
  logic [3:0]  act_dp, act_en, pend_dp, pend_en;
  logic        pend_vld;
  logic [3:0]  blank_vec;
  logic        zero_run;
  logic [3:0]  nib;
  logic        lit;
  logic [3:0]  an_d;
  logic [6:0]  seg_d;
  logic        dp_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  // Stage p0/p1: scan_clk synchroniser; p2: history flop for rising-edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      hist_p2 <= 1'b0;
    end else begin
      sync_p0 <= scan_clk;
      sync_p1 <= sync_p0;
      hist_p2 <= sync_p1;
    end
  end

  assign step = sync_p1 & ~hist_p2;
  assign wrap = (state_q == ST_DRIVE) & step & (digit_idx == 2'd3);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = digit_idx;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == 8'(DEAD_CYCLES - 1)) begin
          state_d = ST_DRIVE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        if (step) begin
          idx_d   = digit_idx + 2'd1;
          state_d = ST_BLANK;
          cnt_d   = 8'd0;
        end
      end
    endcase
  end

  // A digit is blanked when it and every more-significant digit carry no nibble and no dp
  always_comb begin
    blank_vec = 4'b0000;
    zero_run  = 1'b1;
    for (int k = 3; k >= 1; k--) begin
      zero_run     = zero_run & (act_val[4*k +: 4] == 4'h0) & ~act_dp[k];
      blank_vec[k] = BLANK_LEADING & zero_run;
    end
  end

  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    nib   = act_val[{idx_d, 2'b00} +: 4];
    lit   = act_en[idx_d] & ~blank_vec[idx_d];
    if (state_d == ST_DRIVE) begin
      seg_d = seg_decode(nib);
      if (lit) begin
        an_d[idx_d] = 1'b0;
        dp_d        = ~act_dp[idx_d];
      end
    end
  end

  // Output stage: state, index and pin drives all update on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_BLANK;
      cnt_q      <= 8'd0;
      digit_idx  <= 2'd0;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      frame_done <= 1'b0;
      loaded     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      digit_idx  <= idx_d;
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_done <= wrap;
      loaded     <= wrap & (load | pend_vld);
    end
  end

  // Load on the wrap cycle bypasses pending so the freshest data wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_val  <= 16'h0000;
      act_dp   <= 4'h0;
      act_en   <= 4'h0;
      pend_val <= 16'h0000;
      pend_dp  <= 4'h0;
      pend_en  <= 4'h0;
      pend_vld <= 1'b0;
    end else if (wrap) begin
      pend_vld <= 1'b0;
      if (load) begin
        act_val <= value;
        act_dp  <= dp_in;
        act_en  <= digit_en;
      end else if (pend_vld) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
        act_en  <= pend_en;
      end
    end else if (load) begin
      pend_val <= value;
      pend_dp  <= dp_in;
      pend_en  <= digit_en;
      pend_vld <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: each scan step pushes the expected
// DRIVE-phase outputs, and a monitor pops and compares them when the DUT lights the digit.
module tb_seven_seg_scan_ctrl;
  localparam int DEAD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_clk;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        load;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        frame_done;
  logic        loaded;

  seven_seg_scan_ctrl #(.DEAD_CYCLES(DEAD), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .reset(reset), .scan_clk(scan_clk), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .load(load), .an(an), .seg(seg), .dp(dp),
    .digit_idx(digit_idx), .frame_done(frame_done), .loaded(loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] idx;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic       ld;
  } exp_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, m_en, p_dp, p_en;
  logic        m_pv;
  logic [1:0]  m_idx;
  logic [1:0]  prev_idx;
  bit          mon_en    = 1'b0;
  bit          mask_mode = 1'b0;
  int          blank_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic exp_t expect_drive(input logic [1:0] i, input logic fd, input logic ld);
    exp_t e;
    bit   blanked;
    e.idx   = i;
    e.seg   = dec(m_val[int'(i)*4 +: 4]);
    e.fd    = fd;
    e.ld    = ld;
    blanked = 1'b0;
    if (i != 2'd0) begin
      blanked = 1'b1;
      for (int k = int'(i); k < 4; k++)
        if (m_val[k*4 +: 4] != 4'h0 || m_dp[k]) blanked = 1'b0;
    end
    e.an = 4'b1111;
    e.dp = 1'b1;
    if (m_en[i] && !blanked) begin
      e.an[i] = 1'b0;
      e.dp    = ~m_dp[i];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    if (mask_mode) begin
      chk("mask_an0", 32'(an[0]), 32'd1);
      chk("mask_an2", 32'(an[2]), 32'd1);
    end
    if (mon_en) begin
      if (digit_idx != prev_idx) begin
        prev_idx = digit_idx;
        if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
          chk("frame_done", 32'(frame_done), 32'(sb_q[0].fd));
          chk("loaded", 32'(loaded), 32'(sb_q[0].ld));
        end
        chk("dead_an", 32'(an), 32'hF);
        blank_cnt = 1;
      end else if (blank_cnt > 0 && blank_cnt < DEAD) begin
        chk("dead_an", 32'(an), 32'hF);
        chk("fd_idle", 32'(frame_done), 32'd0);
        chk("ld_idle", 32'(loaded), 32'd0);
        blank_cnt++;
      end else if (blank_cnt == DEAD) begin
        blank_cnt = 0;
        if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
          mon_e = sb_q.pop_front();
          chk("drv_idx", 32'(digit_idx), 32'(mon_e.idx));
          chk("drv_an", 32'(an), 32'(mon_e.an));
          chk("drv_seg", 32'(seg), 32'(mon_e.seg));
          chk("drv_dp", 32'(dp), 32'(mon_e.dp));
        end
      end
    end
  end

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    @(negedge clk);
    load = 1'b1; value = v; dp_in = d; digit_en = e;
    @(negedge clk);
    load = 1'b0;
    p_val = v; p_dp = d; p_en = e; m_pv = 1'b1;
  endtask

  task automatic scan_step(input bit ld, input logic [15:0] v, input logic [3:0] d,
                           input logic [3:0] e);
    logic [1:0] nidx;
    logic       wrap, lp;
    @(negedge clk);
    scan_clk = 1'b1;
    @(negedge clk);
    chk("idx_hold1", 32'(digit_idx), 32'(m_idx));
    @(negedge clk);
    chk("idx_hold2", 32'(digit_idx), 32'(m_idx));
    if (ld) begin
      load = 1'b1; value = v; dp_in = d; digit_en = e;
    end
    nidx = m_idx + 2'd1;
    wrap = (m_idx == 2'd3);
    lp   = 1'b0;
    if (wrap) begin
      if (ld) begin
        m_val = v; m_dp = d; m_en = e; m_pv = 1'b0; lp = 1'b1;
      end else if (m_pv) begin
        m_val = p_val; m_dp = p_dp; m_en = p_en; m_pv = 1'b0; lp = 1'b1;
      end
    end else if (ld) begin
      p_val = v; p_dp = d; p_en = e; m_pv = 1'b1;
    end
    m_idx = nidx;
    sb_q.push_back(expect_drive(nidx, wrap, lp));
    @(negedge clk);
    load = 1'b0;
    scan_clk = 1'b0;
    chk("idx_step", 32'(digit_idx), 32'(nidx));
    repeat (8) @(negedge clk);
  endtask

  task automatic model_reset();
    m_val = '0; m_dp = '0; m_en = '0;
    p_val = '0; p_dp = '0; p_en = '0;
    m_pv = 1'b0; m_idx = 2'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; scan_clk = 1'b0; load = 1'b0;
    value = '0; dp_in = '0; digit_en = '0;
    model_reset();

    // reset held while scan_clk and load toggle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      scan_clk = ~scan_clk; load = ~load; value = 16'hFFFF; digit_en = 4'hF;
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_dp", 32'(dp), 32'd1);
      chk("rst_idx", 32'(digit_idx), 32'd0);
      chk("rst_fd", 32'(frame_done), 32'd0);
      chk("rst_ld", 32'(loaded), 32'd0);
    end
    @(negedge clk);
    load = 1'b0; scan_clk = 1'b0; reset = 1'b1;
    repeat (DEAD - 1) @(negedge clk);
    chk("post_rst_blank_seg", 32'(seg), 32'h7F);
    @(negedge clk);
    chk("post_rst_seg", 32'(seg), 32'(7'b1000000));
    chk("post_rst_idx", 32'(digit_idx), 32'd0);
    chk("post_rst_dp", 32'(dp), 32'd1);
    prev_idx = 2'd0;
    mon_en = 1'b1;

    // 0x00A5 with leading-zero blanking, committed at the first wrap
    do_load(16'h00A5, 4'h0, 4'hF);
    repeat (5) scan_step(1'b0, '0, '0, '0);

    // tearing: two loads mid-frame, only the latest appears after the wrap
    do_load(16'h1234, 4'h0, 4'hF);
    scan_step(1'b0, '0, '0, '0);
    do_load(16'h5678, 4'h0, 4'hF);
    repeat (5) scan_step(1'b0, '0, '0, '0);

    // load coincident with the wrap goes straight to active
    scan_step(1'b1, 16'hBEEF, 4'h0, 4'hF);
    repeat (3) scan_step(1'b0, '0, '0, '0);
    scan_step(1'b1, 16'h0100, 4'b0100, 4'hF);
    repeat (3) scan_step(1'b0, '0, '0, '0);

    // digit mask 1010
    scan_step(1'b1, 16'h1111, 4'h0, 4'b1010);
    mask_mode = 1'b1;
    repeat (3) scan_step(1'b0, '0, '0, '0);
    mask_mode = 1'b0;
    do_load(16'h4321, 4'h0, 4'hF);
    repeat (3) scan_step(1'b0, '0, '0, '0);

    // asynchronous reset while digit 2 is lit, with pending data outstanding
    do_load(16'h9999, 4'h0, 4'hF);
    mon_en = 1'b0;
    @(negedge clk);
    chk("pre_rst_an", 32'(an), 32'(4'b1011));
    #2 reset = 1'b0;
    #1;
    chk("async_an", 32'(an), 32'hF);
    chk("async_idx", 32'(digit_idx), 32'd0);
    chk("async_seg", 32'(seg), 32'h7F);
    chk("async_dp", 32'(dp), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (6) @(negedge clk);
    prev_idx = digit_idx;
    blank_cnt = 0;
    mon_en = 1'b1;
    repeat (4) scan_step(1'b0, '0, '0, '0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
